// File: rtl/pipelined_adder_pkg.sv
// Shared constants for the slice-pipelined adder.
package pipelined_adder_pkg;

    // Width of one ripple-carry slice; one slice is added per pipeline stage.
    localparam int SLICE_W = 8;

    // Default slice count, giving a 32-bit adder with four-cycle latency.
    localparam int NUM_SLICES_DEFAULT = 4;

endpackage : pipelined_adder_pkg

// File: rtl/RCA_8bit.sv
// Single ripple-carry adder slice: {C_out, sum} = A_in + B_in + C_in.
module RCA_8bit
    import pipelined_adder_pkg::*;
(
    output logic [SLICE_W-1:0] sum,
    output logic               C_out,
    input  logic [SLICE_W-1:0] A_in,
    input  logic [SLICE_W-1:0] B_in,
    input  logic               C_in
);

    logic [SLICE_W:0] carry;

    // Ripple the carry bit by bit through the slice.
    always_comb begin
        // NOTE: blocking assignments here, so each bit sees the carry just computed for the bit below it.
        carry[0] = C_in;
        sum      = '0;
        for (int i = 0; i < SLICE_W; i++) begin
            sum[i]       = A_in[i] ^ B_in[i] ^ carry[i];
            carry[i + 1] = (A_in[i] & B_in[i]) | (carry[i] & (A_in[i] ^ B_in[i]));
        end
        C_out = carry[SLICE_W];
    end

endmodule : RCA_8bit

// File: rtl/pipelined_adder_32bit.sv
// Slice-pipelined adder with valid/ready handshake on both sides.
// Stage k adds slice k using the carry registered by stage k-1; operand
// slices travel down the pipeline until their stage, and finished low
// slices ride along so the whole sum leaves the last stage together.
// The whole pipeline freezes while the result is held by the consumer.
// Requires NUM_SLICES >= 2.
module pipelined_adder_32bit
    import pipelined_adder_pkg::*;
#(
    parameter int NUM_SLICES = NUM_SLICES_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SLICE_W*NUM_SLICES-1:0] A_in,
    input  logic [SLICE_W*NUM_SLICES-1:0] B_in,
    input  logic                          C_in,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [SLICE_W*NUM_SLICES-1:0] sum,
    output logic                          C_out,
    output logic                          overflow,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam int W    = SLICE_W * NUM_SLICES;
    localparam int LAST = NUM_SLICES - 1;

    // Operands are only needed by stages that still have a slice to add.
    logic [W-1:0]          a_q [NUM_SLICES-1];
    logic [W-1:0]          a_d [NUM_SLICES-1];
    logic [W-1:0]          b_q [NUM_SLICES-1];
    logic [W-1:0]          b_d [NUM_SLICES-1];
    logic [W-1:0]          s_q [NUM_SLICES];
    logic [W-1:0]          s_d [NUM_SLICES];
    logic [NUM_SLICES-1:0] c_q, c_d;
    logic [NUM_SLICES-1:0] v_q, v_d;
    logic                  ovf_q, ovf_d;
    logic                  stall;

    logic [SLICE_W-1:0]    rca_a  [NUM_SLICES];
    logic [SLICE_W-1:0]    rca_b  [NUM_SLICES];
    logic [SLICE_W-1:0]    rca_s  [NUM_SLICES];
    logic [NUM_SLICES-1:0] rca_ci;
    logic [NUM_SLICES-1:0] rca_co;

    for (genvar k = 0; k < NUM_SLICES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign rca_a[k]  = A_in[SLICE_W-1:0];
            assign rca_b[k]  = B_in[SLICE_W-1:0];
            assign rca_ci[k] = C_in;
        end else begin : g_rest
            assign rca_a[k]  = a_q[k-1][k*SLICE_W +: SLICE_W];
            assign rca_b[k]  = b_q[k-1][k*SLICE_W +: SLICE_W];
            assign rca_ci[k] = c_q[k-1];
        end

        RCA_8bit u_rca (
            .sum   (rca_s[k]),
            .C_out (rca_co[k]),
            .A_in  (rca_a[k]),
            .B_in  (rca_b[k]),
            .C_in  (rca_ci[k])
        );
    end

    // Advance every stage by one unless the held result blocks the pipe.
    always_comb begin
        // NOTE: every next-state variable gets its hold value first, so no path leaves it unassigned and no latch is inferred.
        stall = v_q[LAST] & ~out_ready;
        a_d   = a_q;
        b_d   = b_q;
        s_d   = s_q;
        c_d   = c_q;
        v_d   = v_q;
        ovf_d = ovf_q;

        if (!stall) begin
            a_d[0]                 = A_in;
            b_d[0]                 = B_in;
            s_d[0]                 = '0;
            s_d[0][SLICE_W-1:0]    = rca_s[0];
            c_d[0]                 = rca_co[0];
            v_d[0]                 = in_valid;

            for (int k = 1; k < LAST; k++) begin
                a_d[k] = a_q[k-1];
                b_d[k] = b_q[k-1];
            end

            for (int k = 1; k < NUM_SLICES; k++) begin
                s_d[k]                        = s_q[k-1];
                s_d[k][k*SLICE_W +: SLICE_W]  = rca_s[k];
                c_d[k]                        = rca_co[k];
                v_d[k]                        = v_q[k-1];
            end

            // Carry into the MSB is recovered from the MSB sum bit.
            ovf_d = (rca_a[LAST][SLICE_W-1] ^ rca_b[LAST][SLICE_W-1] ^ rca_s[LAST][SLICE_W-1])
                    ^ rca_co[LAST];
        end
    end

    // Pipeline registers; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data registers are cleared too, so sum/C_out/overflow read zero straight out of reset.
            a_q   <= '{default: '0};
            b_q   <= '{default: '0};
            s_q   <= '{default: '0};
            c_q   <= '0;
            v_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
            c_q   <= c_d;
            v_q   <= v_d;
            ovf_q <= ovf_d;
        end
    end

    assign in_ready  = ~stall;
    assign sum       = s_q[LAST];
    assign C_out     = c_q[LAST];
    assign overflow  = ovf_q;
    assign out_valid = v_q[LAST];

endmodule : pipelined_adder_32bit

// File: tb/tb_pipelined_adder_32bit.sv
// Self-checking bench: directed corner cases plus randomized traffic with
// random backpressure, compared against an arithmetic reference model.
module tb_pipelined_adder_32bit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] A_in, B_in;
    logic         C_in, in_valid, in_ready;
    logic [W-1:0] sum;
    logic         C_out, overflow, out_valid, out_ready;

    int n_checks  = 0;
    int n_pass    = 0;
    int n_results = 0;

    // Expected {C_out, overflow, sum} in acceptance order.
    logic [W+1:0] exp_q [$];

    pipelined_adder_32bit #(.NUM_SLICES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .A_in      (A_in),
        .B_in      (B_in),
        .C_in      (C_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .C_out     (C_out),
        .overflow  (overflow),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    // Reference: plain unsigned and signed arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic ci);
        longint unsigned u;
        longint          s;
        logic            ovf;
        u   = longint'({32'b0, a}) + longint'({32'b0, b}) + longint'({63'b0, ci});
        s   = longint'(signed'(a)) + longint'(signed'(b)) + longint'({63'b0, ci});
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return {u[W], ovf, u[W-1:0]};
    endfunction

    // Monitor: scoreboard, handshake rule and hold-while-stalled checks.
    logic         prev_stall = 1'b0;
    logic [W+1:0] held;
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            check("in_ready_rule", in_ready, !(out_valid && !out_ready));
            if (prev_stall) begin
                check("hold_result", {C_out, overflow, sum}, held);
                check("hold_valid", out_valid, 1'b1);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", out_valid, 1'b0);
                end else begin
                    automatic logic [W+1:0] e = exp_q.pop_front();
                    check("result", {C_out, overflow, sum}, e);
                    n_results++;
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(A_in, B_in, C_in));
            prev_stall = out_valid && !out_ready;
            held       = {C_out, overflow, sum};
        end
    end

    // Offer one operation and hold it until accepted (bounded).
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        logic acc;
        acc      = 1'b0;
        A_in     = a;
        B_in     = b;
        C_in     = ci;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        in_valid = 1'b0;
        check("accepted", acc, 1'b1);
    endtask

    // Let all outstanding results leave the pipe (bounded).
    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++)
            @(negedge clk);
        @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst       = 1'b1;
        A_in      = '0;
        B_in      = '0;
        C_in      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sum", sum, 32'h0);
        check("rst_flags", {C_out, overflow}, 2'b00);
        check("rst_in_ready", in_ready, 1'b1);

        // First-result latency and value.
        send(32'h7, 32'h9, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("latency_early", out_valid, 1'b0);
        end
        @(negedge clk);
        check("latency_valid", out_valid, 1'b1);
        check("small_sum", sum, 32'h10);
        check("small_flags", {C_out, overflow}, 2'b00);
        @(posedge clk);
        #1;

        // Carry rippling across every slice, signed overflow, carry-in.
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        send(32'h0000_00FF, 32'h0000_0000, 1'b1);
        drain();

        // Six back-to-back ops, consumer stalls 3 cycles from first result.
        base      = n_results;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(32'h0101_0101 * (i + 1), 32'hFF00_00FF - i, i[0]);
            end
            begin
                bit seen;
                seen = 1'b0;
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                check("stall_first_valid", seen, 1'b1);
                check("stall_in_ready", in_ready, 1'b0);
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("stall_delivered", n_results - base, 6);

        // Reset with two ops in flight: neither may emerge.
        send(32'h1234_5678, 32'h1111_1111, 1'b0);
        send(32'hDEAD_BEEF, 32'h0000_0001, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_sum", sum, 32'h0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        base = n_results;
        repeat (8) begin
            @(negedge clk);
            check("no_ghost", out_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        check("ghost_count", n_results - base, 0);

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            A_in      = pick();
            B_in      = pick();
            C_in      = $urandom_range(0, 1) != 0;
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pipelined_adder_32bit

// File: doc/pipelined_adder_32bit.md
PIPELINED_ADDER_32BIT -- requirements
Module: pipelined_adder_32bit

Interface
REQ-001 SHALL have parameter NUM_SLICES, default 4, number of 8-bit adder slices and pipeline stages; operand width W = 8*NUM_SLICES.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port A_in  input  W  operand A.
REQ-005 SHALL have port B_in  input  W  operand B.
REQ-006 SHALL have port C_in  input  1  carry-in to slice 0.
REQ-007 SHALL have port in_valid  input  1  operands valid this cycle.
REQ-008 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-009 SHALL have port sum  output  W  registered result.
REQ-010 SHALL have port C_out  output  1  carry-out of the MSB slice.
REQ-011 SHALL have port overflow  output  1  two's-complement overflow flag.
REQ-012 SHALL have port out_valid  output  1  sum/C_out/overflow valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts result this cycle.

Function
REQ-014 SHALL accept an operation on a cycle where in_valid and in_ready are both 1.
REQ-015 SHALL compute {C_out,sum} = A_in + B_in + C_in, modulo 2^(W+1).
REQ-016 SHALL add slice k (bits 8k+7..8k) in pipeline stage k, using the registered carry from stage k-1 (stage 0 uses C_in).
REQ-017 SHALL skew operands: slice k bits delayed k cycles; completed low slices delayed so all bits appear together.
REQ-018 SHALL assert out_valid exactly NUM_SLICES cycles after acceptance when no stall occurs (latency 4 at default).
REQ-019 SHALL keep one valid bit per stage; bubbles propagate as invalid stages.
REQ-020 SHALL define stall = out_valid AND NOT out_ready; during stall all pipeline registers and outputs hold.
REQ-021 SHALL drive in_ready = NOT stall (combinational); operands offered while stalled are not accepted.
REQ-022 SHALL set overflow = carry into MSB XOR C_out, registered with sum.
REQ-023 SHALL hold sum, C_out, overflow stable while out_valid=1 and out_ready=0.
REQ-024 SHALL sustain one accepted operation per cycle when out_ready stays 1 (full throughput).
REQ-025 SHALL preserve operation order; no result is dropped or duplicated under any out_ready pattern.
REQ-026 SHALL, with out_valid=0, let the pipeline advance regardless of out_ready.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, clear all stage valid bits, sum=0, C_out=0, overflow=0, out_valid=0.
REQ-028 SHALL discard all in-flight operations on reset; rst has priority over accept and stall.
REQ-029 SHALL drive in_ready=1 in the first cycle after reset is released.

Structure
REQ-030 SHALL place SLICE_W=8 and default NUM_SLICES in a shared package pipelined_adder_pkg.
REQ-031 SHALL instantiate the existing RCA_8bit module (ports sum, C_out, A_in, B_in, C_in) once per stage as its only sub-module.
REQ-032 SHALL contain no combinational path from A_in/B_in to sum.

Verification
REQ-033 SHALL check: accept 0x00000007 + 0x00000009, C_in=0, out_ready=1 -> 4 cycles later out_valid=1, sum=0x00000010, C_out=0, overflow=0.
REQ-034 SHALL check: 0xFFFFFFFF + 0x00000001, C_in=0 -> sum=0x00000000, C_out=1, overflow=0 (carry crosses all slices).
REQ-035 SHALL check: 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, C_out=0, overflow=1; 0x000000FF + 0, C_in=1 -> sum=0x00000100.
REQ-036 SHALL check: 6 back-to-back ops with out_ready=0 for 3 cycles after first out_valid -> in_ready=0 during stall, result held, all 6 results delivered in order.
REQ-037 SHALL check: rst=1 for one cycle with 2 ops in flight -> next cycle out_valid=0, sum=0; neither op ever emerges.
